// File: rtl/axi_pkg.sv
// Shared AXI read-side types and constants for the memory slave adapters.
// Bus widths live here as localparams so every block sees one definition.
package axi_pkg;

  localparam int unsigned AXI_ID_BITS   = 8;
  localparam int unsigned AXI_ADDR_BITS = 32;
  localparam int unsigned AXI_DATA_BITS = 32;
  localparam int unsigned AXI_LEN_BITS  = 4;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_e;

  localparam logic [2:0] SIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LOAD,
    DATA
  } rd_state_e;

  // Only full-word FIXED/INCR bursts are served; anything else answers SLVERR.
  function automatic logic rd_req_err(input logic [2:0] size, input logic [1:0] burst);
    return (size != SIZE_WORD) || (burst inside {2'b10, 2'b11});
  endfunction

endpackage

// File: rtl/slave_read_if.sv
// AXI4 read address/data channel bundle between interconnect (master) and slave_read.
interface slave_read_if #(
  parameter int unsigned ID_BITS   = 8,
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned DATA_BITS = 32
);
  logic [ID_BITS-1:0]   ARID_S;
  logic [ADDR_BITS-1:0] ARADDR_S;
  logic [3:0]           ARLEN_S;
  logic [2:0]           ARSIZE_S;
  logic [1:0]           ARBURST_S;
  logic                 ARVALID_S;
  logic                 ARREADY_S;

  logic [ID_BITS-1:0]   RID_S;
  logic [DATA_BITS-1:0] RDATA_S;
  logic [1:0]           RRESP_S;
  logic                 RLAST_S;
  logic                 RVALID_S;
  logic                 RREADY_S;

  modport master (
    output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S, RREADY_S,
    input  ARREADY_S, RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S
  );

  modport slave (
    input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S, RREADY_S,
    output ARREADY_S, RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S
  );
endinterface

// File: rtl/slave_read_addr_gen.sv
// Word address and beat counter for one read burst; INCR steps the address,
// FIXED holds it. The address wraps naturally at the SRAM depth.
module slave_read_addr_gen
  import axi_pkg::*;
#(
  parameter int unsigned SRAM_AW = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [SRAM_AW-1:0] load_addr,
  input  logic [3:0]         load_len,
  input  logic [1:0]         load_burst,
  output logic [SRAM_AW-1:0] addr,
  output logic               last
);

  logic [SRAM_AW-1:0] addr_q;
  logic [3:0]         beat_q;
  logic [3:0]         len_q;
  logic               incr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      beat_q <= '0;
      len_q  <= '0;
      incr_q <= 1'b0;
    end else if (load) begin
      addr_q <= load_addr;
      beat_q <= '0;
      len_q  <= load_len;
      incr_q <= (load_burst == INCR);
    end else if (step) begin
      beat_q <= beat_q + 4'd1;
      if (incr_q) addr_q <= addr_q + 1'b1;
    end
  end

  assign addr = addr_q;
  assign last = (beat_q == len_q);

endmodule

// File: rtl/slave_read.sv
// AXI4 read-channel slave in front of a synchronous single-port SRAM:
// one burst at a time, each beat fetched (FETCH), captured (LOAD), then held (DATA).
module slave_read
  import axi_pkg::*;
#(
  parameter int unsigned ID_BITS   = 8,
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned SRAM_AW   = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  slave_read_if.slave          axi,
  output logic                 sram_cs,
  output logic [SRAM_AW-1:0]   sram_addr,
  input  logic [DATA_BITS-1:0] sram_rdata
);

  rd_state_e            state_q, state_d;
  logic                 arready_q;
  logic [ID_BITS-1:0]   id_q;
  logic                 err_q;
  logic [DATA_BITS-1:0] rdata_q;

  logic                 ar_fire;
  logic                 step;
  logic [SRAM_AW-1:0]   word_addr;
  logic                 last;
  logic                 unused_addr_bits;

  assign ar_fire = axi.ARVALID_S && arready_q;
  assign step    = (state_q == DATA) && axi.RREADY_S && !last;

  // Interconnect owns decode: high address bits and the byte offset are dropped.
  assign unused_addr_bits = ^{axi.ARADDR_S[ADDR_BITS-1:SRAM_AW+2], axi.ARADDR_S[1:0]};

  slave_read_addr_gen #(
    .SRAM_AW (SRAM_AW)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (ar_fire),
    .step       (step),
    .load_addr  (axi.ARADDR_S[SRAM_AW+1:2]),
    .load_len   (axi.ARLEN_S),
    .load_burst (axi.ARBURST_S),
    .addr       (word_addr),
    .last       (last)
  );

  // ARREADY is registered off the next state so it is low during reset
  // and never depends combinationally on the R channel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      arready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      arready_q <= (state_d == IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (ar_fire) state_d = FETCH;
      FETCH: state_d = LOAD;
      LOAD:  state_d = DATA;
      DATA:  if (axi.RREADY_S) state_d = last ? IDLE : FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_q    <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (ar_fire) begin
        id_q  <= axi.ARID_S;
        err_q <= rd_req_err(axi.ARSIZE_S, axi.ARBURST_S);
      end
      if (state_q == LOAD) rdata_q <= err_q ? '0 : sram_rdata;
    end
  end

  always_comb begin
    axi.ARREADY_S = arready_q;
    axi.RVALID_S  = 1'b0;
    axi.RDATA_S   = '0;
    axi.RID_S     = '0;
    axi.RRESP_S   = OKAY;
    axi.RLAST_S   = 1'b0;
    sram_cs       = 1'b0;
    sram_addr     = '0;
    unique case (state_q)
      FETCH: begin
        sram_cs   = !err_q;
        sram_addr = word_addr;
      end
      DATA: begin
        axi.RVALID_S = 1'b1;
        axi.RDATA_S  = rdata_q;
        axi.RID_S    = id_q;
        axi.RRESP_S  = err_q ? SLVERR : OKAY;
        axi.RLAST_S  = last;
      end
      default: ;
    endcase
  end

endmodule
